// File: rtl/uart_tx_engine.sv
// uart_tx_engine: FIFO-buffered UART transmitter producing start/data/parity/stop frames.
// Bit period is the latched BRR divisor, clamped to at least 16 clk.
module uart_tx_engine #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_en,
   input  logic             cfg_pce,
   input  logic             cfg_ps,
   input  logic             cfg_stop2,
   input  logic [15:0]      cfg_brr,
   input  logic [CNT_W-1:0] cfg_txft,
   input  logic [7:0]       s_axis_tdata,
   input  logic             s_axis_tvalid,
   output logic             s_axis_tready,
   output logic             tx_o,
   output logic             tc_o,
   output logic             txfe_o,
   output logic             txft_o,
   output logic             busy_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;
   logic [7:0] mem [FIFO_DEPTH];
   logic [CNT_W-1:0] wptr, rptr, wptr_nx, rptr_nx, level, level_nx;
   logic rdy, push, pop, empty, tc_nx, bit_end, txd;
   logic [7:0] dat;
   logic pce, ps, stop2, scnt;
   logic [2:0] bcnt;
   logic [15:0] cnt, brr_eff;
   assign level    = wptr - rptr;
   assign empty    = level == '0;
   assign push     = s_axis_tvalid && rdy;
   assign wptr_nx  = wptr + CNT_W'(push);
   assign rptr_nx  = rptr + CNT_W'(pop);
   assign level_nx = wptr_nx - rptr_nx;
   assign bit_end  = cnt == brr_eff - 16'd1;
   assign s_axis_tready = rdy;
   assign tx_o   = txd;
   assign busy_o = state != IDLE;
   always_ff @(posedge clk)
      if (push) mem[wptr[AW-1:0]] <= s_axis_tdata;
   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      tc_nx    = 1'b0;
      txd      = 1'b1;
      case (state)
         IDLE: if (cfg_en && !empty) begin
            state_nx = START;
            pop      = 1'b1;
         end
         START: begin
            txd = 1'b0;
            if (bit_end) state_nx = DATA;
         end
         DATA: begin
            txd = dat[bcnt];
            if (bit_end && bcnt == 3'd7) state_nx = pce ? PARITY : STOP;
         end
         PARITY: begin
            txd = ^dat ^ ps;
            if (bit_end) state_nx = STOP;
         end
         STOP: if (bit_end && (!stop2 || scnt)) begin
            // chain straight into the next start bit when more data is waiting
            if (cfg_en && !empty) begin
               state_nx = START;
               pop      = 1'b1;
            end else begin
               state_nx = IDLE;
               tc_nx    = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         wptr    <= '0;
         rptr    <= '0;
         rdy     <= 1'b0;
         tc_o    <= 1'b0;
         txfe_o  <= 1'b1;
         txft_o  <= 1'b1;
         cnt     <= '0;
         bcnt    <= '0;
         scnt    <= 1'b0;
         dat     <= '0;
         pce     <= 1'b0;
         ps      <= 1'b0;
         stop2   <= 1'b0;
         brr_eff <= 16'd16;
      end else begin
         state  <= state_nx;
         wptr   <= wptr_nx;
         rptr   <= rptr_nx;
         rdy    <= level_nx != CNT_W'(FIFO_DEPTH);
         tc_o   <= tc_nx;
         txfe_o <= empty;
         txft_o <= (level <= cfg_txft);
         cnt    <= (state == IDLE || bit_end) ? 16'd0 : cnt + 16'd1;
         bcnt   <= bcnt + 3'((state == DATA) && bit_end);
         if (state == STOP && bit_end) scnt <= stop2 && !scnt;
         if (pop) begin
            dat     <= mem[rptr[AW-1:0]];
            pce     <= cfg_pce;
            ps      <= cfg_ps;
            stop2   <= cfg_stop2;
            brr_eff <= (cfg_brr < 16'd16) ? 16'd16 : cfg_brr;
         end
      end
   end
endmodule
